// File: rtl/adma_xfer_engine.sv
// ADMA data mover between system RAM and the card-side FIFO, one descriptor per start.
// Defining ADMA_XFER_WATCHDOG_EN adds a stall watchdog that ends the transfer with xfer_error.

module adma_xfer_engine #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 64,
    parameter int LEN_WIDTH   = 16,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    start,
    input  logic                    direction,
    input  logic                    abort,
    input  logic [ADDR_WIDTH-1:0]   address_init,
    input  logic [LEN_WIDTH-1:0]    length,
    output logic [ADDR_WIDTH-1:0]   ram_address,
    output logic                    ram_read,
    output logic                    ram_write,
    output logic [DATA_WIDTH/8-1:0] ram_be,
    input  logic [DATA_WIDTH-1:0]   data_from_ram,
    output logic [DATA_WIDTH-1:0]   data_to_ram,
    output logic                    fifo_read,
    output logic                    fifo_write,
    input  logic [DATA_WIDTH-1:0]   data_from_fifo,
    output logic [DATA_WIDTH-1:0]   data_to_fifo,
    input  logic                    fifo_full,
    input  logic                    fifo_empty,
    output logic                    busy,
    output logic                    TFC,
    output logic                    aborted,
    output logic                    xfer_error
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int BSHIFT = $clog2(BYTES);
    localparam int WW     = LEN_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        R2F_RD,
        R2F_WR,
        F2R,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WW-1:0]           words_q, words_d;
    logic [BSHIFT-1:0]       rem_q, rem_d;

    logic [WW-1:0]           len_full;
    logic [WW-1:0]           words_init;
    logic [BYTES-1:0]        be_last;
    logic [BYTES-1:0]        be_word;
    logic                    stall;
    logic                    moved;

`ifdef ADMA_XFER_WATCHDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    logic [WDW-1:0]          wdog_q, wdog_d;
`else
    localparam int unused_wdog_cycles = WDOG_CYCLES;
    logic                    unused_flags;
    assign unused_flags = stall | moved;
`endif

    // A length of zero stands for the full 2**LEN_WIDTH bytes, hence the extra bit.
    assign len_full    = (length == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, length};
    assign words_init  = (len_full + WW'(BYTES - 1)) >> BSHIFT;
    assign ram_address = addr_q;
    assign busy        = (state_q != IDLE);

    always_comb begin
        for (int i = 0; i < BYTES; i++) begin
            be_last[i] = (i < int'(rem_q));
        end
        be_word = ((words_q == WW'(1)) && (rem_q != '0)) ? be_last : '1;
    end

    // Data is forwarded in the same cycle as its strobe so push/write and word stay aligned.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_d      = words_q;
        rem_d        = rem_q;
        ram_read     = 1'b0;
        ram_write    = 1'b0;
        ram_be       = '0;
        data_to_ram  = '0;
        fifo_read    = 1'b0;
        fifo_write   = 1'b0;
        data_to_fifo = '0;
        TFC          = 1'b0;
        aborted      = 1'b0;
        xfer_error   = 1'b0;
        stall        = 1'b0;
        moved        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = address_init;
                    words_d = words_init;
                    rem_d   = length[BSHIFT-1:0];
                    state_d = direction ? F2R : R2F_RD;
                end
            end
            R2F_RD: begin
                if (abort) begin
                    state_d = DONE;
                end else if (!fifo_full) begin
                    ram_read = 1'b1;
                    state_d  = R2F_WR;
                end else begin
                    stall = 1'b1;
                end
            end
            R2F_WR: begin
                fifo_write   = 1'b1;
                data_to_fifo = data_from_ram;
                addr_d       = addr_q + ADDR_WIDTH'(BYTES);
                words_d      = words_q - WW'(1);
                moved        = 1'b1;
                state_d      = ((words_q == WW'(1)) || abort) ? DONE : R2F_RD;
            end
            F2R: begin
                if (!fifo_empty) begin
                    fifo_read   = 1'b1;
                    ram_write   = 1'b1;
                    ram_be      = be_word;
                    data_to_ram = data_from_fifo;
                    addr_d      = addr_q + ADDR_WIDTH'(BYTES);
                    words_d     = words_q - WW'(1);
                    moved       = 1'b1;
                    state_d     = ((words_q == WW'(1)) || abort) ? DONE : F2R;
                end else if (abort) begin
                    state_d = DONE;
                end else begin
                    stall = 1'b1;
                end
            end
            DONE: begin
                TFC     = (words_q == '0);
                aborted = (words_q != '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef ADMA_XFER_WATCHDOG_EN
        wdog_d = wdog_q;
        if ((state_q == IDLE) || moved) begin
            wdog_d = '0;
        end else if (stall) begin
            if (wdog_q == WDW'(WDOG_CYCLES - 1)) begin
                xfer_error = 1'b1;
                state_d    = IDLE;
                wdog_d     = '0;
            end else begin
                wdog_d = wdog_q + WDW'(1);
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            words_q <= '0;
            rem_q   <= '0;
`ifdef ADMA_XFER_WATCHDOG_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            rem_q   <= rem_d;
`ifdef ADMA_XFER_WATCHDOG_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

endmodule
